// File: rtl/random_server.sv
// random_server: round-robin arbitrated front end for a shared Fibonacci LFSR.
// Each grant hands out the current LFSR word for one cycle, then the LFSR
// advances one step. Seeding and all-zero recovery are handled internally.
module random_server #(
   parameter int               WIDTH = 3,
   parameter logic [WIDTH-1:0] TAPS  = 3'b101,
   parameter logic [WIDTH-1:0] SEED  = 3'b001,
   parameter int               N_REQ = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic             rand_valid,
   output logic [WIDTH-1:0] rand_data,
   output logic             busy
);

   localparam int               PTR_W    = $clog2(N_REQ);
   localparam logic [PTR_W:0]   N_REQ_L  = (PTR_W+1)'(N_REQ);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_GRANT = 2'b01,
      ST_WAIT  = 2'b10
   } state_t;

   // One Fibonacci step: shift left, feedback from the tapped bits.
   function automatic logic [WIDTH-1:0] f_lfsr_step(input logic [WIDTH-1:0] v);
      return {v[WIDTH-2:0], ^(v & TAPS)};
   endfunction

   state_t             r_state, w_state_next;
   logic [WIDTH-1:0]   r_lfsr, w_lfsr_next;
   logic [PTR_W-1:0]   r_rr_ptr, w_rr_ptr_next;
   logic [PTR_W-1:0]   r_owner, w_owner_next;
   logic [N_REQ-1:0]   r_grant, w_grant_next;
   logic               r_valid, w_valid_next;
   logic [WIDTH-1:0]   r_data, w_data_next;
   logic               r_busy;
   logic               w_found;
   logic [PTR_W-1:0]   w_winner;

   // Round-robin search: first requester at or above rr_ptr, wrapping.
   always_comb begin
      logic [PTR_W:0] idx;
      w_found  = 1'b0;
      w_winner = '0;
      idx      = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(i);
         if (idx >= N_REQ_L) begin
            idx = idx - N_REQ_L;
         end else begin
            idx = idx;
         end
         if (!w_found && req[idx[PTR_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = idx[PTR_W-1:0];
         end else begin
            w_found  = w_found;
         end
      end
   end

   // Next-state, next-output and LFSR update decisions.
   always_comb begin
      w_state_next  = r_state;
      w_rr_ptr_next = r_rr_ptr;
      w_owner_next  = r_owner;
      w_grant_next  = '0;
      w_valid_next  = 1'b0;
      w_data_next   = '0;
      w_lfsr_next   = r_lfsr;

      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_next = ST_GRANT;
               w_grant_next = {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
               w_valid_next = 1'b1;
               w_data_next  = r_lfsr;
               w_owner_next = w_winner;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_GRANT: begin
            w_lfsr_next   = f_lfsr_step(r_lfsr);
            w_rr_ptr_next = (r_owner == LAST_IDX) ? '0 : r_owner + PTR_W'(1);
            if (req[r_owner]) begin
               w_state_next = ST_WAIT;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (req[r_owner]) begin
               w_state_next = ST_WAIT;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase

      // Seed load beats the grant advance; a zero seed maps to SEED.
      if (seed_load) begin
         w_lfsr_next = (seed == '0) ? SEED : seed;
      end else if (r_lfsr == '0) begin
         w_lfsr_next = SEED;
      end else begin
         w_lfsr_next = w_lfsr_next;
      end
   end

   // State, LFSR, pointer and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_lfsr   <= SEED;
         r_rr_ptr <= '0;
         r_owner  <= '0;
         r_grant  <= '0;
         r_valid  <= 1'b0;
         r_data   <= '0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_lfsr   <= w_lfsr_next;
         r_rr_ptr <= w_rr_ptr_next;
         r_owner  <= w_owner_next;
         r_grant  <= w_grant_next;
         r_valid  <= w_valid_next;
         r_data   <= w_data_next;
         r_busy   <= (w_state_next != ST_IDLE);
      end
   end

   assign grant      = r_grant;
   assign rand_valid = r_valid;
   assign rand_data  = r_data;
   assign busy       = r_busy;

endmodule

// File: tb/tb_random_server.sv
// Directed testbench for random_server with default parameters.
module tb_random_server;

   logic       clk;
   logic       reset;
   logic       seed_load;
   logic [2:0] seed;
   logic [3:0] req;
   logic [3:0] grant;
   logic       rand_valid;
   logic [2:0] rand_data;
   logic       busy;

   int checks;
   int errors;

   logic [2:0] seq_tab [0:7];
   logic [3:0] oh_tab  [0:3];

   random_server dut (
      .clk        (clk),
      .reset      (reset),
      .seed_load  (seed_load),
      .seed       (seed),
      .req        (req),
      .grant      (grant),
      .rand_valid (rand_valid),
      .rand_data  (rand_data),
      .busy       (busy)
   );

   // 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_grant"}, {4'd0, grant}, 8'h00);
      chk({tag, "_valid"}, {7'd0, rand_valid}, 8'h00);
      chk({tag, "_data"}, {5'd0, rand_data}, 8'h00);
      chk({tag, "_busy"}, {7'd0, busy}, 8'h00);
   endtask

   task automatic chk_grant(input string tag, input logic [3:0] g, input logic [2:0] d);
      chk({tag, "_grant"}, {4'd0, grant}, {4'd0, g});
      chk({tag, "_valid"}, {7'd0, rand_valid}, 8'h01);
      chk({tag, "_data"}, {5'd0, rand_data}, {5'd0, d});
      chk({tag, "_busy"}, {7'd0, busy}, 8'h01);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      seq_tab[0] = 3'b001; seq_tab[1] = 3'b011; seq_tab[2] = 3'b111; seq_tab[3] = 3'b110;
      seq_tab[4] = 3'b101; seq_tab[5] = 3'b010; seq_tab[6] = 3'b100; seq_tab[7] = 3'b001;
      oh_tab[0] = 4'b0001; oh_tab[1] = 4'b0010; oh_tab[2] = 4'b0100; oh_tab[3] = 4'b1000;

      reset     = 1'b0;
      seed_load = 1'b0;
      seed      = 3'b000;
      req       = 4'b0000;

      // Reset state
      step();
      step();
      chk_idle("rst");
      reset = 1'b1;

      // Single requester, dropped in each grant cycle
      for (int k = 0; k < 8; k++) begin
         req = 4'b0001;
         step();
         chk_grant($sformatf("single%0d", k), 4'b0001, seq_tab[k]);
         req = 4'b0000;
         step();
         chk_idle($sformatf("single%0d_after", k));
      end

      // Asynchronous reset in the middle of a GRANT cycle
      req = 4'b0001;
      step();
      chk_grant("pre_rst", 4'b0001, 3'b011);
      #2;
      reset = 1'b0;
      #1;
      chk_idle("async_rst");
      req = 4'b0000;
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Fairness: all request, each drops one cycle after its grant
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         step();
         chk_grant($sformatf("fair%0d", k), oh_tab[k % 4], seq_tab[k]);
         step();
         chk($sformatf("fair%0d_wait_busy", k), {7'd0, busy}, 8'h01);
         chk($sformatf("fair%0d_wait_grant", k), {4'd0, grant}, 8'h00);
         req = req & ~oh_tab[k % 4];
         step();
         chk($sformatf("fair%0d_idle_busy", k), {7'd0, busy}, 8'h00);
         req = 4'b1111;
      end

      // Hold: req[2] held after grant blocks req[0]
      req = 4'b0101;
      step();
      chk_grant("hold_g2", 4'b0100, 3'b010);
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("hold%0d_busy", k), {7'd0, busy}, 8'h01);
         chk($sformatf("hold%0d_grant", k), {4'd0, grant}, 8'h00);
      end
      req = 4'b0001;
      step();
      chk_idle("hold_drop");
      step();
      chk_grant("hold_g0", 4'b0001, 3'b100);
      req = 4'b0000;
      step();
      chk_idle("hold_end");

      // Seeding: seed 110 loaded during a GRANT cycle outputting 011
      req = 4'b0001;
      step();
      chk_grant("seed_a", 4'b0001, 3'b001);
      req = 4'b0000;
      step();
      req = 4'b0001;
      step();
      chk_grant("seed_b", 4'b0001, 3'b011);
      seed_load = 1'b1;
      seed      = 3'b110;
      req       = 4'b0000;
      step();
      seed_load = 1'b0;
      chk_idle("seed_b_after");
      req = 4'b0001;
      step();
      chk_grant("seed_c", 4'b0001, 3'b110);
      req = 4'b0000;
      step();
      // Zero seed maps to SEED
      seed_load = 1'b1;
      seed      = 3'b000;
      step();
      seed_load = 1'b0;
      chk_idle("seed_zero_idle");
      req = 4'b0001;
      step();
      chk_grant("seed_zero", 4'b0001, 3'b001);
      req = 4'b0000;
      step();

      // Reset during WAIT_DROP
      req = 4'b0001;
      step();
      chk_grant("wd_g", 4'b0001, 3'b011);
      step();
      chk("wd_busy", {7'd0, busy}, 8'h01);
      #2;
      reset = 1'b0;
      #1;
      chk_idle("wd_rst");
      req = 4'b0000;
      @(posedge clk);
      #1;
      reset = 1'b1;
      req   = 4'b0010;
      step();
      chk_grant("post_rst", 4'b0010, 3'b001);
      req = 4'b0000;
      step();
      chk_idle("post_rst_end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/random_server.md
# random_server

Arbitrated front end for the team's Fibonacci pseudo-random generator. It owns one WIDTH-bit LFSR and shares it between N_REQ requesters. Round-robin arbitration picks one requester at a time, that requester gets one fresh random word, and the LFSR then advances exactly one step. It also handles seeding and all-zero lock-up recovery, so requesters never drive the LFSR directly.

## Interface
- WIDTH, 3, LFSR width (3..16).
- TAPS, 3'b101, feedback mask; feedback bit = XOR-reduce(lfsr & TAPS).
- SEED, 3'b001, reset/recovery value; must be non-zero.
- N_REQ, 4, number of requesters (2..8).
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low. Low clears everything immediately.
- seed_load  input  1  load seed into the LFSR at the next edge.
- seed  input  WIDTH  value to load.
- req  input  N_REQ  per-requester request, level. Held high until the grant is seen.
- grant  output  N_REQ  one-hot grant, registered.
- rand_valid  output  1  high exactly when a grant bit is high.
- rand_data  output  WIDTH  random word; valid with rand_valid, otherwise 0.
- busy  output  1  high whenever the FSM is not IDLE.

## Operation
- LFSR step: lfsr_next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}. With the defaults, starting from 001 the sequence is 001→011→111→110→101→010→100→001 (period 7).
- Registers: lfsr, rr_ptr (log2 N_REQ bits), owner index, FSM state, and the registered outputs.
- FSM states:
  - IDLE:
    - If any req is high, the winner is the first set bit scanning upward from rr_ptr, wrapping modulo N_REQ.
    - Go to GRANT. Register grant = onehot(winner), rand_valid = 1, rand_data = current lfsr, owner = winner.
  - GRANT (one cycle):
    - At the edge leaving GRANT, lfsr advances one step and rr_ptr = (owner+1) mod N_REQ.
    - Outputs clear.
    - Next state is WAIT_DROP if req[owner] is still high, else IDLE.
  - WAIT_DROP:
    - Stay while req[owner] = 1.
    - Go to IDLE on the first edge that samples req[owner] = 0.
    - Other requests wait.
- seed_load:
  - Honoured in every state.
  - Next lfsr = seed, or SEED if seed == 0.
  - Overrides the GRANT advance in the same cycle.
  - Does not change FSM state or outputs.
- Lock-up guard: if lfsr is ever all-zero at an edge and no seed load is pending, next lfsr = SEED.
- A requester that keeps req high after WAIT_DROP competes again. It only wins if no other requester with higher round-robin priority is asking.

## Timing
- Reset (reset = 0, asynchronous), all immediately:
  - lfsr = SEED, rr_ptr = 0, state = IDLE.
  - grant = 0, rand_valid = 0, rand_data = 0, busy = 0.
- Leaving reset: the first edge with reset = 1 is evaluated normally.
- Latency: req sampled high at IDLE edge k → grant/rand_valid/rand_data valid during cycle k..k+1.
- Minimum service interval is 2 cycles per grant: IDLE, GRANT, IDLE when req drops during the GRANT cycle.
- rand_data carries the pre-advance lfsr. Consecutive grants therefore return consecutive sequence values regardless of which requester receives them.
- Reset asserted during GRANT or WAIT_DROP: outputs drop asynchronously and the grant is not completed. The lfsr goes back to SEED (no partial advance).
- Simultaneous seed_load and grant exit: the loaded value wins, and the granted requester still receives the old value.
- Simultaneous requests: at most one grant bit is ever high. No requester waits more than N_REQ-1 grants.

## Test plan
- Reset check: hold reset = 0 mid-cycle → all outputs 0, busy 0 asynchronously. Release, then req = 0001 → rand_data = 001 in the grant cycle.
- Single requester sequence: req[0] pulses 8 times, dropped in each grant cycle → rand_data 001, 011, 111, 110, 101, 010, 100, 001. Grants are 2 cycles apart.
- Fairness: req = 1111 held, each requester drops its req one cycle after its grant and re-raises it → grant order 0001, 0010, 0100, 1000, 0001. rand_data follows the sequence.
- Hold behaviour: req[2] held 5 cycles after its grant, req[0] high throughout → busy stays 1 and no grant is issued. grant = 0001 arrives 2 cycles after req[2] falls.
- Seeding: seed_load = 1, seed = 000 → next grant returns 001. seed = 110 asserted in a GRANT cycle that outputs 011 → next grant returns 110, not 111.
- Mid-operation reset: assert reset during WAIT_DROP → grant = 0 immediately. After release, req[1] → grant = 0010 with rand_data = 001.
